// File: rtl/y86_memory_stage_if.sv
// rtl/y86_memory_stage_if.sv - execute-side request and writeback-side response bundle for the Y86 memory stage
interface y86_memory_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [63:0] out_valE;
    logic [63:0] valM;
    logic [2:0]  stat;

    modport master (
        output in_valid, icode, valE, valA, valP, out_ready,
        input  in_ready, out_valid, out_icode, out_valE, valM, stat
    );

    modport slave (
        input  in_valid, icode, valE, valA, valP, out_ready,
        output in_ready, out_valid, out_icode, out_valE, valM, stat
    );
endinterface

// File: rtl/y86_memory_stage.sv
// rtl/y86_memory_stage.sv - Y86-64 memory stage with byte-addressed little-endian data memory
module y86_memory_stage #(
    parameter int MEM_BYTES = 1024
) (
    input logic             clk,
    input logic             rst,
    y86_memory_stage_if.slave bus
);
    localparam int          AW         = $clog2(MEM_BYTES);
    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES - 8);
    localparam logic [2:0]  STAT_AOK   = 3'd1;
    localparam logic [2:0]  STAT_HLT   = 3'd2;
    localparam logic [2:0]  STAT_ADR   = 3'd3;
    localparam logic [2:0]  STAT_INS   = 3'd4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [3:0]  r_icode;
    logic [63:0] r_valE;
    logic [63:0] r_valA;
    logic [63:0] r_valP;
    logic [63:0] r_valM;
    logic [2:0]  r_stat;

    logic [7:0]  mem [MEM_BYTES];

    logic        do_write;
    logic        do_read;
    logic        addr_err;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [2:0]  dec_stat;
    logic [AW-1:0] base;

    always_comb begin
        do_write = 1'b0;
        do_read  = 1'b0;
        addr     = r_valE;
        wdata    = r_valA;
        dec_stat = STAT_AOK;
        case (r_icode)
            4'h4, 4'hA: do_write = 1'b1;
            4'h8: begin
                do_write = 1'b1;
                wdata    = r_valP;
            end
            4'h5: do_read = 1'b1;
            4'h9, 4'hB: begin
                do_read = 1'b1;
                addr    = r_valA;
            end
            4'h0: dec_stat = STAT_HLT;
            4'h1, 4'h2, 4'h3, 4'h6, 4'h7: dec_stat = STAT_AOK;
            default: dec_stat = STAT_INS;
        endcase
    end

    // Full 64-bit compare so huge addresses never wrap into the array.
    assign addr_err = (do_write || do_read) && (addr > ADDR_LIMIT);
    assign base     = addr[AW-1:0];

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    // Memory has no reset; a reset landing on the ACCESS edge cancels the store.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && do_write && !addr_err) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r_icode <= '0;
            r_valE  <= '0;
            r_valA  <= '0;
            r_valP  <= '0;
            r_valM  <= '0;
            r_stat  <= STAT_AOK;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_icode <= bus.icode;
                        r_valE  <= bus.valE;
                        r_valA  <= bus.valA;
                        r_valP  <= bus.valP;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_valM <= (do_read && !addr_err) ? rdata : 64'd0;
                    r_stat <= addr_err ? STAT_ADR : dec_stat;
                    state  <= RESP;
                end
                RESP: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == RESP);
    assign bus.out_icode = r_icode;
    assign bus.out_valE  = r_valE;
    assign bus.valM      = r_valM;
    assign bus.stat      = r_stat;
endmodule
